apb_req_arbiter: RTL
====================

// Module: apb_req_arbiter
// PURPOSE
//  APB requester-side controller: arbitrates two local requesters onto one APB
//  master port and runs the APB SETUP/ACCESS sequence for the memory slave.
//  Round-robin grant, PREADY wait states, per-transfer wait timeout, and
//  per-requester read-data/done/error return. Sits between CPU/DMA-style
//  requesters and the APB memory slave.
// PARAMETERS
//  ADDWIDTH   8   APB address width
//  DATAWIDTH  32  APB data width (multiple of 8)
//  TIMEOUT    16  max ACCESS cycles with PREADY=0 before abort; 0 = never abort
// PORTS
//  PCLK        in   1            clock; all logic on rising edge
//  PRESETn     in   1            asynchronous reset, active-low
//  reqN_valid  in   1            (N=0,1) request present; hold fields until reqN_ready
//  reqN_write  in   1            1=write, 0=read
//  reqN_addr   in   ADDWIDTH     target address
//  reqN_wdata  in   DATAWIDTH    write data
//  reqN_strb   in   DATAWIDTH/8  byte strobes (writes only)
//  reqN_ready  out  1            1-cycle pulse: request accepted
//  reqN_done   out  1            1-cycle pulse: transfer finished
//  reqN_err    out  1            valid with reqN_done: 1 = timed out
//  reqN_rdata  out  DATAWIDTH    read data, valid at reqN_done, held until next done
//  PSEL        out  1            APB select
//  PENABLE     out  1            APB enable
//  PWRITE      out  1            APB direction
//  PADDR       out  ADDWIDTH     APB address
//  PWDATA      out  DATAWIDTH    APB write data
//  PSTRB       out  DATAWIDTH/8  APB write strobes
//  PREADY      in   1            slave ready
//  PRDATA      in   DATAWIDTH    slave read data
// BEHAVIOUR
//  - Reset (async, PRESETn=0): FSM=IDLE, all outputs 0, wait counter 0,
//    round-robin pointer favours req0. Reset mid-transfer aborts with no done pulse.
//  - FSM IDLE -> SETUP -> ACCESS -> IDLE; all outputs registered.
//  - IDLE: if any reqN_valid, grant: one valid -> it; both -> requester not served
//    last (after reset: req0). On the IDLE->SETUP edge latch write/addr/wdata/strb
//    into PWRITE/PADDR/PWDATA/PSTRB, assert granted reqN_ready for the SETUP cycle.
//  - Reads drive PSTRB=0, PWDATA=0. APB outputs stay stable SETUP through ACCESS.
//  - SETUP: PSEL=1, PENABLE=0; always -> ACCESS next cycle.
//  - ACCESS: PSEL=1, PENABLE=1. PREADY=1 -> capture PRDATA into reqN_rdata (reads;
//    writes leave rdata unchanged), pulse reqN_done with err=0 in the following
//    (IDLE) cycle, PSEL/PENABLE=0, update RR pointer.
//  - PREADY=0 in ACCESS: wait counter +1. If TIMEOUT!=0 and counter reaches TIMEOUT
//    with PREADY still 0: abort -> IDLE, reqN_done=1, reqN_err=1, reqN_rdata=0.
//    Counter clears on every IDLE->SETUP. PREADY=1 on the TIMEOUT-th cycle wins.
//  - Minimum 3 cycles per transfer (SETUP, ACCESS, IDLE); no back-to-back SETUP.
//  - Requester may re-assert valid right after its ready pulse; it is considered
//    only in IDLE. Valid dropped before ready = request withdrawn (legal).
//  - Never more than one reqN_ready/reqN_done high in a cycle.
// TESTING
//  1. req0 write addr 0x10 data 0xDEADBEEF strb 0xF, zero-wait slave -> ready0 in
//     SETUP, PENABLE next cycle, done0=1 err0=0 cycle after; mem[0x10]=0xDEADBEEF.
//  2. req0 write 0x10 data 0x0000AAAA strb 0x3, then req1 read 0x10 -> rdata1=0xDEADAAAA,
//     PSTRB=0 and PWDATA=0 during the read.
//  3. Both valid held from reset, 4 transfers each -> grant order 0,1,0,1,...;
//     done pulses never overlap.
//  4. Slave holds PREADY=0 for 2 ACCESS cycles -> PSEL/PENABLE/PADDR stable, done after
//     PREADY=1, err=0; PREADY=0 forever with TIMEOUT=4 -> done err=1 rdata=0 after 4.
//  5. PRESETn low during ACCESS -> PSEL/PENABLE=0 immediately, no done; after release
//     pending req1 and req0 valid -> req0 granted first.

Source files
------------

// File: rtl/apb_req_arbiter_if.sv
// APB master-side bus bundle between the requester arbiter and the memory slave.
// Master drives select/enable/address/data; slave returns ready and read data.
interface apb_req_arbiter_if #(
  parameter int ADDWIDTH  = 8,
  parameter int DATAWIDTH = 32
);
  logic                   PSEL;
  logic                   PENABLE;
  logic                   PWRITE;
  logic [ADDWIDTH-1:0]    PADDR;
  logic [DATAWIDTH-1:0]   PWDATA;
  logic [DATAWIDTH/8-1:0] PSTRB;
  logic                   PREADY;
  logic [DATAWIDTH-1:0]   PRDATA;

  modport master (
    output PSEL, PENABLE, PWRITE,
    output PADDR, PWDATA, PSTRB,
    input  PREADY, PRDATA
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE,
    input  PADDR, PWDATA, PSTRB,
    output PREADY, PRDATA
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin front end driving one APB master port.
// Runs SETUP/ACCESS, tolerates wait states, aborts on wait timeout.
module apb_req_arbiter #(
  parameter int ADDWIDTH  = 8,
  parameter int DATAWIDTH = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   req0_valid,
  input  logic                   req0_write,
  input  logic [ADDWIDTH-1:0]    req0_addr,
  input  logic [DATAWIDTH-1:0]   req0_wdata,
  input  logic [DATAWIDTH/8-1:0] req0_strb,
  output logic                   req0_ready,
  output logic                   req0_done,
  output logic                   req0_err,
  output logic [DATAWIDTH-1:0]   req0_rdata,
  input  logic                   req1_valid,
  input  logic                   req1_write,
  input  logic [ADDWIDTH-1:0]    req1_addr,
  input  logic [DATAWIDTH-1:0]   req1_wdata,
  input  logic [DATAWIDTH/8-1:0] req1_strb,
  output logic                   req1_ready,
  output logic                   req1_done,
  output logic                   req1_err,
  output logic [DATAWIDTH-1:0]   req1_rdata,
  apb_req_arbiter_if.master      apb
);
  localparam int SW = DATAWIDTH / 8;
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]           state;
  logic                 owner;
  logic                 last;
  logic [CW-1:0]        wcnt;
  logic                 to_hit;

  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [ADDWIDTH-1:0]  paddr;
  logic [DATAWIDTH-1:0] pwdata;
  logic [SW-1:0]        pstrb;

  logic                 gsel;
  logic                 s_write;
  logic [ADDWIDTH-1:0]  s_addr;
  logic [DATAWIDTH-1:0] s_wdata;
  logic [SW-1:0]        s_strb;

  assign apb.PSEL    = psel;
  assign apb.PENABLE = penable;
  assign apb.PWRITE  = pwrite;
  assign apb.PADDR   = paddr;
  assign apb.PWDATA  = pwdata;
  assign apb.PSTRB   = pstrb;

  // Grant pick: lone requester wins, a tie goes to whoever was not served last.
  always_comb begin
    gsel = 1'b0;
    unique case (1'b1)
      (req0_valid & req1_valid):  gsel = ~last;
      (req1_valid & ~req0_valid): gsel = 1'b1;
      default:                    gsel = 1'b0;
    endcase
  end

  assign s_write = gsel ? req1_write : req0_write;
  assign s_addr  = gsel ? req1_addr  : req0_addr;
  assign s_wdata = gsel ? req1_wdata : req0_wdata;
  assign s_strb  = gsel ? req1_strb  : req0_strb;

  assign to_hit = (TIMEOUT != 0) && (wcnt == CW'(TIMEOUT - 1));

  // Transfer sequencer: grant, APB phases, completion/abort return.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last       <= 1'b1;
      wcnt       <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      pstrb      <= '0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
      req0_err   <= 1'b0;
      req1_err   <= 1'b0;
      req0_rdata <= '0;
      req1_rdata <= '0;
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
      req0_err   <= 1'b0;
      req1_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req0_valid | req1_valid) begin
            state   <= SETUP;
            owner   <= gsel;
            wcnt    <= '0;
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= s_write;
            paddr   <= s_addr;
            pwdata  <= s_write ? s_wdata : '0;
            pstrb   <= s_write ? s_strb : '0;
            if (gsel) req1_ready <= 1'b1;
            else      req0_ready <= 1'b1;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          if (apb.PREADY) begin
            state   <= IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
            last    <= owner;
            if (owner) begin
              req1_done <= 1'b1;
              if (!pwrite) req1_rdata <= apb.PRDATA;
            end else begin
              req0_done <= 1'b1;
              if (!pwrite) req0_rdata <= apb.PRDATA;
            end
          end else if (to_hit) begin
            state   <= IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
            last    <= owner;
            if (owner) begin
              req1_done  <= 1'b1;
              req1_err   <= 1'b1;
              req1_rdata <= '0;
            end else begin
              req0_done  <= 1'b1;
              req0_err   <= 1'b1;
              req0_rdata <= '0;
            end
          end else if (wcnt != '1) begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
